// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM burst responder.
// Optional burst statistics are enabled by DRAM_STAT_EN.
package dram_pkg;
   localparam int BLOCK_SIZE_C = 8;
   localparam int WORD_W       = 32;

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      RD_WAIT,
      RD_BURST,
      DONE
   } dram_state_t;
endpackage

// File: rtl/dram_mem_array.sv
// Single-port word RAM: synchronous write, registered read.
// The read register returns zero in cycles without a read.
module dram_mem_array
   import dram_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = WORD_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_rdata;

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read register, cleared when no read is issued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end else begin
         r_rdata <= '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_burst_resp.sv
// DRAM-side block responder for the dcache: 8-beat write-backs and fills.
// Define DRAM_STAT_EN to add saturating per-direction burst counters.
module dram_burst_resp
   import dram_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int BLOCK_SIZE = BLOCK_SIZE_C,
   parameter int RD_LAT     = 4,
   parameter int BEAT_GAP   = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              dram_wr_req,
   input  logic [WORD_W-1:0] dram_wr_addr,
   input  logic [WORD_W-1:0] dram_wr_data,
   output logic              dram_wr_val,
   input  logic              dram_rd_req,
   input  logic [WORD_W-1:0] dram_rd_addr,
   output logic [WORD_W-1:0] dram_rd_data,
   output logic              dram_rd_val
`ifdef DRAM_STAT_EN
   ,
   output logic [15:0]       wr_burst_cnt,
   output logic [15:0]       rd_burst_cnt
`endif
);

   localparam int BEAT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int CNT_W  = 16;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);
   localparam logic [CNT_W-1:0]  GAP_C     = CNT_W'(BEAT_GAP);
   localparam logic [CNT_W-1:0]  LAT_C     = CNT_W'(RD_LAT - 1);

   dram_state_t        r_state;
   dram_state_t        w_state_nxt;
   logic [ADDR_W-1:0]  r_base;
   logic [ADDR_W-1:0]  w_base_nxt;
   logic [BEAT_W-1:0]  r_beat;
   logic [BEAT_W-1:0]  w_beat_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_wr_mode;
   logic               w_wr_mode_nxt;
   logic               r_wr_val;
   logic               w_wr_val_nxt;
   logic               r_rd_val;
   logic               w_rd_issue;
   logic               w_we;
   logic [ADDR_W-1:0]  w_mem_addr;
   logic [WORD_W-1:0]  w_rd_data;
   logic               w_unused;

   // Upper address bits are deliberately ignored.
   assign w_unused = ^{dram_wr_addr[WORD_W-1:ADDR_W],
                       dram_rd_addr[WORD_W-1:ADDR_W]};

   // Beat index wraps inside the ADDR_W-bit word space.
   assign w_mem_addr = r_base + ADDR_W'(r_beat);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, beat pacing and memory strobes.
   always_comb begin
      w_state_nxt   = r_state;
      w_base_nxt    = r_base;
      w_beat_nxt    = r_beat;
      w_cnt_nxt     = r_cnt;
      w_wr_mode_nxt = r_wr_mode;
      w_wr_val_nxt  = 1'b0;
      w_rd_issue    = 1'b0;
      w_we          = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (dram_wr_req) begin
               w_base_nxt    = dram_wr_addr[ADDR_W-1:0];
               w_beat_nxt    = '0;
               w_cnt_nxt     = CNT_W'(1);
               w_wr_mode_nxt = 1'b1;
               w_state_nxt   = WR_BURST;
            end else if (dram_rd_req) begin
               w_base_nxt    = dram_rd_addr[ADDR_W-1:0];
               w_beat_nxt    = '0;
               w_cnt_nxt     = LAT_C;
               w_wr_mode_nxt = 1'b0;
               w_state_nxt   = RD_WAIT;
            end
         end
         WR_BURST: begin
            if (r_wr_val) begin
               w_we      = 1'b1;
               w_cnt_nxt = r_cnt - 1'b1;
               if (r_beat == LAST_BEAT) begin
                  w_state_nxt = DONE;
               end else begin
                  w_beat_nxt = r_beat + 1'b1;
               end
            end else if (r_cnt == '0) begin
               w_wr_val_nxt = 1'b1;
               w_cnt_nxt    = GAP_C;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         RD_WAIT: begin
            if (r_cnt == '0) begin
               w_rd_issue  = 1'b1;
               w_cnt_nxt   = GAP_C;
               w_beat_nxt  = r_beat + 1'b1;
               w_state_nxt = RD_BURST;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         RD_BURST: begin
            if (r_cnt == '0) begin
               w_rd_issue = 1'b1;
               w_cnt_nxt  = GAP_C;
               if (r_beat == LAST_BEAT) begin
                  w_state_nxt = DONE;
               end else begin
                  w_beat_nxt = r_beat + 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         DONE: begin
            if (r_wr_mode ? !dram_wr_req : !dram_rd_req) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Burst bookkeeping and valid pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_base    <= '0;
         r_beat    <= '0;
         r_cnt     <= '0;
         r_wr_mode <= 1'b0;
         r_wr_val  <= 1'b0;
         r_rd_val  <= 1'b0;
      end else begin
         r_base    <= w_base_nxt;
         r_beat    <= w_beat_nxt;
         r_cnt     <= w_cnt_nxt;
         r_wr_mode <= w_wr_mode_nxt;
         r_wr_val  <= w_wr_val_nxt;
         r_rd_val  <= w_rd_issue;
      end
   end

   dram_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (WORD_W)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_we),
      .i_re    (w_rd_issue),
      .i_addr  (w_mem_addr),
      .i_wdata (dram_wr_data),
      .o_rdata (w_rd_data)
   );

   assign dram_wr_val  = r_wr_val;
   assign dram_rd_val  = r_rd_val;
   assign dram_rd_data = w_rd_data;

`ifdef DRAM_STAT_EN
   logic [15:0] r_wr_cnt;
   logic [15:0] r_rd_cnt;

   // Completed-burst counters, saturating at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
      end else begin
         if (r_state == WR_BURST && w_state_nxt == DONE &&
             r_wr_cnt != 16'hFFFF) begin
            r_wr_cnt <= r_wr_cnt + 16'd1;
         end
         if (r_state == RD_BURST && w_state_nxt == DONE &&
             r_rd_cnt != 16'hFFFF) begin
            r_rd_cnt <= r_rd_cnt + 16'd1;
         end
      end
   end

   assign wr_burst_cnt = r_wr_cnt;
   assign rd_burst_cnt = r_rd_cnt;
`endif

endmodule
